if_fetch_stage: RTL

- Pipelined instruction-fetch stage; sits directly upstream of the decode stage and drives the IF/ID pipeline register.
- Holds the PC and issues one instruction-memory read at a time over a req/ack handshake.
- Selects next PC from interrupt entry, redirect (branch/jump resolved downstream) or PC+4.
- Honours decode stall via a one-entry pending buffer; flushes on redirect/interrupt.

---
 rtl/if_fetch_stage_if.sv | 24 ++
 rtl/if_fetch_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory read channel between the fetch stage and instruction memory.
// One request outstanding at a time: imem_addr is held while imem_req=1 and unacked.
interface if_fetch_stage_if #(
   parameter int XLEN = 32
) ();
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic            imem_ack;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ack
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ack
   );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single outstanding imem reads and
// loads the IF/ID register, with a one-entry pending buffer for decode stalls.
module if_fetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'd128
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                int_req,
   input  logic [XLEN-1:0]     entry_point,
   input  logic                redirect,
   input  logic [XLEN-1:0]     redirect_pc,
   input  logic                stall,
   if_fetch_stage_if.master    imem,
   output logic                id_valid,
   output logic [XLEN-1:0]     id_ins,
   output logic [XLEN-1:0]     id_pc,
   output logic [XLEN-1:0]     id_pcp4
);

   typedef enum logic [1:0] {
      S_START,
      S_FETCH,
      S_DISCARD,
      S_PEND
   } state_t;

   state_t          r_state,    w_state_nx;
   logic [XLEN-1:0] r_pc,       w_pc_nx;
   logic [XLEN-1:0] r_req_addr, w_req_addr_nx;
   logic            r_id_valid, w_id_valid_nx;
   logic [XLEN-1:0] r_id_ins,   w_id_ins_nx;
   logic [XLEN-1:0] r_id_pc,    w_id_pc_nx;
   logic [XLEN-1:0] r_id_pcp4,  w_id_pcp4_nx;
   logic [XLEN-1:0] r_pend_ins, w_pend_ins_nx;
   logic [XLEN-1:0] r_pend_pc,  w_pend_pc_nx;

   logic            w_flush;
   logic [XLEN-1:0] w_target;
   logic            w_accept;
   logic [XLEN-1:0] w_req_pcp4;

   always_comb begin
      w_flush    = int_req | redirect;
      w_target   = int_req ? entry_point : redirect_pc;
      w_accept   = !r_id_valid || !stall;
      w_req_pcp4 = r_req_addr + XLEN'(4);

      w_state_nx    = r_state;
      w_pc_nx       = r_pc;
      w_req_addr_nx = r_req_addr;
      w_id_valid_nx = r_id_valid;
      w_id_ins_nx   = r_id_ins;
      w_id_pc_nx    = r_id_pc;
      w_id_pcp4_nx  = r_id_pcp4;
      w_pend_ins_nx = r_pend_ins;
      w_pend_pc_nx  = r_pend_pc;

      // Flush overrides stall; the pending entry is abandoned by leaving S_PEND.
      if (w_flush) begin
         w_pc_nx       = w_target;
         w_id_valid_nx = 1'b0;
      end

      case (r_state)
         S_START: begin
            w_state_nx = S_FETCH;
            if (w_flush) w_req_addr_nx = w_target;
         end

         S_FETCH: begin
            if (w_flush) begin
               if (imem.imem_ack) w_req_addr_nx = w_target;
               else               w_state_nx    = S_DISCARD;
            end else if (imem.imem_ack) begin
               if (w_accept) begin
                  w_id_valid_nx = 1'b1;
                  w_id_ins_nx   = imem.imem_rdata;
                  w_id_pc_nx    = r_req_addr;
                  w_id_pcp4_nx  = w_req_pcp4;
                  w_pc_nx       = w_req_pcp4;
                  w_req_addr_nx = w_req_pcp4;
               end else begin
                  w_pend_ins_nx = imem.imem_rdata;
                  w_pend_pc_nx  = r_req_addr;
                  w_pc_nx       = w_req_pcp4;
                  w_state_nx    = S_PEND;
               end
            end else if (w_accept) begin
               w_id_valid_nx = 1'b0;
            end
         end

         S_DISCARD: begin
            if (!w_flush && w_accept) w_id_valid_nx = 1'b0;
            if (imem.imem_ack) begin
               w_req_addr_nx = w_flush ? w_target : r_pc;
               w_state_nx    = S_FETCH;
            end
         end

         S_PEND: begin
            // r_pc already equals the pending PC + 4 here.
            if (w_flush) begin
               w_req_addr_nx = w_target;
               w_state_nx    = S_FETCH;
            end else if (!stall) begin
               w_id_valid_nx = 1'b1;
               w_id_ins_nx   = r_pend_ins;
               w_id_pc_nx    = r_pend_pc;
               w_id_pcp4_nx  = r_pc;
               w_req_addr_nx = r_pc;
               w_state_nx    = S_FETCH;
            end
         end

         default: w_state_nx = S_START;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_START;
         r_pc       <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_id_valid <= 1'b0;
         r_id_ins   <= '0;
         r_id_pc    <= '0;
         r_id_pcp4  <= '0;
         r_pend_ins <= '0;
         r_pend_pc  <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_pc       <= w_pc_nx;
         r_req_addr <= w_req_addr_nx;
         r_id_valid <= w_id_valid_nx;
         r_id_ins   <= w_id_ins_nx;
         r_id_pc    <= w_id_pc_nx;
         r_id_pcp4  <= w_id_pcp4_nx;
         r_pend_ins <= w_pend_ins_nx;
         r_pend_pc  <= w_pend_pc_nx;
      end
   end

   always_comb begin
      imem.imem_req  = (r_state == S_FETCH) || (r_state == S_DISCARD);
      imem.imem_addr = r_req_addr;
   end

   assign id_valid = r_id_valid;
   assign id_ins   = r_id_ins;
   assign id_pc    = r_id_pc;
   assign id_pcp4  = r_id_pcp4;

endmodule
